// File: rtl/tlb_cam_array.sv
// Fully associative TLB tag CAM: per-entry valid bits, multi-port registered lookup,
// explicit/auto (free-slot then round-robin) write, invalidate-by-key and purge.
module tlb_cam_port #(
  parameter int ENTRIES   = 8,
  parameter int KEY_WIDTH = 36,
  parameter int AW        = 3
) (
  input  logic [ENTRIES-1:0][KEY_WIDTH-1:0] keys,
  input  logic [ENTRIES-1:0]                valid,
  input  logic [KEY_WIDTH-1:0]              pattern,
  output logic [AW-1:0]                     hitIdx,
  output logic                              hit,
  output logic                              multi
);
  logic [ENTRIES-1:0] hitVec;

  always_comb begin
    hitVec = '0;
    for (int i = 0; i < ENTRIES; i++)
      hitVec[i] = valid[i] && (keys[i] == pattern);
  end

  // Scan downward so the lowest matching index is the last one written.
  always_comb begin
    hitIdx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (hitVec[i]) hitIdx = AW'(i);
  end

  assign hit   = |hitVec;
  // Clearing the lowest set bit leaves something only if two or more matched.
  assign multi = |(hitVec & (hitVec - ENTRIES'(1)));
endmodule

module tlb_cam_array #(
  parameter int ENTRIES   = 8,
  parameter int KEY_WIDTH = 36,
  parameter int PORTS     = 2,
  localparam int AW       = $clog2(ENTRIES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORTS*KEY_WIDTH-1:0] pattern,
  input  logic                       wEnable,
  input  logic                       wAuto,
  input  logic [AW-1:0]              writeAdr,
  input  logic [KEY_WIDTH-1:0]       wKey,
  input  logic                       invEnable,
  input  logic [KEY_WIDTH-1:0]       invKey,
  input  logic                       purge,
  output logic [PORTS*AW-1:0]        matchAdr,
  output logic [PORTS-1:0]           mFound,
  output logic [PORTS-1:0]           mMulti,
  output logic [AW-1:0]              wAdrUsed,
  output logic                       full,
  output logic [AW:0]                validCnt
);
  logic [ENTRIES-1:0][KEY_WIDTH-1:0] keys;
  logic [ENTRIES-1:0]                valid;
  logic [AW-1:0]                     rrPtr;

  logic [PORTS-1:0][AW-1:0] lkIdx;
  logic [PORTS-1:0]         lkHit, lkMulti;

  for (genvar p = 0; p < PORTS; p++) begin : gPort
    tlb_cam_port #(.ENTRIES(ENTRIES), .KEY_WIDTH(KEY_WIDTH), .AW(AW)) uPort (
      .keys   (keys),
      .valid  (valid),
      .pattern(pattern[p*KEY_WIDTH +: KEY_WIDTH]),
      .hitIdx (lkIdx[p]),
      .hit    (lkHit[p]),
      .multi  (lkMulti[p])
    );
  end

  logic [ENTRIES-1:0] invHit;
  logic               freeFound;
  logic [AW-1:0]      freeIdx, wSlot;
  logic [AW:0]        cnt;

  always_comb begin
    invHit    = '0;
    freeFound = 1'b0;
    freeIdx   = '0;
    cnt       = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      invHit[i] = invEnable && valid[i] && (keys[i] == invKey);
      cnt       = cnt + (AW+1)'(valid[i]);
    end
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!valid[i]) begin
        freeFound = 1'b1;
        freeIdx   = AW'(i);
      end
  end

  assign wSlot    = !wAuto ? writeAdr : (freeFound ? freeIdx : rrPtr);
  assign full     = &valid;
  assign validCnt = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= '0;
      rrPtr    <= '0;
      wAdrUsed <= '0;
      matchAdr <= '0;
      mFound   <= '0;
      mMulti   <= '0;
    end else begin
      matchAdr <= lkIdx;
      mFound   <= lkHit;
      mMulti   <= lkMulti;
      if (purge) begin
        valid <= '0;
        rrPtr <= '0;
      end else begin
        // Write applied after invalidate so a colliding write slot stays valid.
        valid <= valid & ~invHit;
        if (wEnable) begin
          valid[wSlot] <= 1'b1;
          wAdrUsed     <= wSlot;
          if (wAuto && !freeFound) rrPtr <= rrPtr + AW'(1);
        end
      end
    end
  end

  // Key storage carries no reset; contents are meaningless while invalid.
  always_ff @(posedge clk) begin
    if (wEnable && !purge) keys[wSlot] <= wKey;
  end
endmodule
